// File: rtl/softreg_arbiter.sv
// Round-robin arbiter sharing one MIDAS soft-register channel among NUM_REQ requesters.
// Requests are registered into a one-entry slot; read tags are kept in order to route responses.
module softreg_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0]          req_wr,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          resp_valid,
    output logic [DATA_W-1:0]           resp_rdata,
    input  logic                        io_softreg_req_ready,
    output logic                        io_softreg_req_valid,
    output logic [ADDR_W-1:0]           io_softreg_req_bits_addr,
    output logic [DATA_W-1:0]           io_softreg_req_bits_wdata,
    output logic                        io_softreg_req_bits_wr,
    output logic                        io_softreg_resp_ready,
    input  logic                        io_softreg_resp_valid,
    input  logic [DATA_W-1:0]           io_softreg_resp_bits_rdata,
    output logic                        err_unexpected_resp
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    logic [ID_W-1:0]    rr_ptr_r;
    logic [ID_W-1:0]    win_id_s;
    logic               win_found_s;
    logic [NUM_REQ-1:0] eligible_s;
    logic               load_en_s;
    logic               grant_s;
    logic               read_grant_s;
    logic               resp_hs_s;
    logic [ID_W-1:0]    head_id_s;

    logic               slot_valid_r;
    logic               slot_wr_r;
    logic [ADDR_W-1:0]  slot_addr_r;
    logic [DATA_W-1:0]  slot_wdata_r;

    logic [ID_W-1:0]    tag_mem_r [MAX_OUTSTANDING];
    logic [PTR_W-1:0]   tag_wptr_r;
    logic [PTR_W-1:0]   tag_rptr_r;
    logic [CNT_W-1:0]   out_cnt_r;
    logic               err_r;

    // A read counts against the limit from the moment it is granted into the slot.
    always_comb begin
        eligible_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible_s[i] = req_valid[i] & (req_wr[i] | (out_cnt_r < CNT_W'(MAX_OUTSTANDING)));
        end
    end

    // Round-robin search: first eligible requester at or after the pointer.
    always_comb begin
        logic [ID_W-1:0] idx_s;
        logic            hit_s;
        idx_s       = '0;
        hit_s       = 1'b0;
        win_id_s    = '0;
        win_found_s = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s       = ID_W'((int'(rr_ptr_r) + k) % NUM_REQ);
            hit_s       = !win_found_s && eligible_s[idx_s];
            win_id_s    = hit_s ? idx_s : win_id_s;
            win_found_s = win_found_s | hit_s;
        end
    end

    assign load_en_s    = !slot_valid_r || io_softreg_req_ready;
    assign grant_s      = load_en_s && win_found_s;
    assign read_grant_s = grant_s && !req_wr[win_id_s];
    assign resp_hs_s    = io_softreg_resp_valid && (out_cnt_r != CNT_W'(0));
    assign head_id_s    = tag_mem_r[tag_rptr_r];

    // Grant strobe and response routing to the requester at the head of the tag FIFO.
    always_comb begin
        req_ready             = '0;
        req_ready[win_id_s]   = grant_s;
        resp_valid            = '0;
        resp_valid[head_id_s] = resp_hs_s;
        resp_rdata            = resp_hs_s ? io_softreg_resp_bits_rdata : '0;
    end

    assign io_softreg_resp_ready     = (out_cnt_r != CNT_W'(0));
    assign io_softreg_req_valid      = slot_valid_r;
    assign io_softreg_req_bits_addr  = slot_addr_r;
    assign io_softreg_req_bits_wdata = slot_wdata_r;
    assign io_softreg_req_bits_wr    = slot_wr_r;
    assign err_unexpected_resp       = err_r;

    // Output slot and round-robin pointer; fields only change when the slot reloads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid_r <= 1'b0;
            slot_wr_r    <= 1'b0;
            slot_addr_r  <= '0;
            slot_wdata_r <= '0;
            rr_ptr_r     <= '0;
        end else if (grant_s) begin
            slot_valid_r <= 1'b1;
            slot_wr_r    <= req_wr[win_id_s];
            slot_addr_r  <= req_addr[int'(win_id_s)*ADDR_W +: ADDR_W];
            slot_wdata_r <= req_wdata[int'(win_id_s)*DATA_W +: DATA_W];
            rr_ptr_r     <= (win_id_s == ID_W'(NUM_REQ - 1)) ? '0 : win_id_s + 1'b1;
        end else if (io_softreg_req_ready) begin
            slot_valid_r <= 1'b0;
        end
    end

    // Tag FIFO and outstanding-read count; the count doubles as FIFO occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                tag_mem_r[i] <= '0;
            end
            tag_wptr_r <= '0;
            tag_rptr_r <= '0;
            out_cnt_r  <= '0;
        end else begin
            if (read_grant_s) begin
                tag_mem_r[tag_wptr_r] <= win_id_s;
                tag_wptr_r            <= tag_wptr_r + 1'b1;
            end
            if (resp_hs_s) begin
                tag_rptr_r <= tag_rptr_r + 1'b1;
            end
            case ({read_grant_s, resp_hs_s})
                2'b10:   out_cnt_r <= out_cnt_r + CNT_W'(1);
                2'b01:   out_cnt_r <= out_cnt_r - CNT_W'(1);
                default: out_cnt_r <= out_cnt_r;
            endcase
        end
    end

    // Sticky flag for a response arriving with no read outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (io_softreg_resp_valid && (out_cnt_r == CNT_W'(0))) begin
            err_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_softreg_arbiter.sv
// Directed bench for softreg_arbiter: acts as requesters and as the MIDAS side,
// with request and response scoreboards checked by a negedge monitor.
module tb_softreg_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_wr;
    logic [63:0] req_addr;
    logic [127:0] req_wdata;
    logic [1:0]  resp_valid;
    logic [63:0] resp_rdata;
    logic        io_softreg_req_ready;
    logic        io_softreg_req_valid;
    logic [31:0] io_softreg_req_bits_addr;
    logic [63:0] io_softreg_req_bits_wdata;
    logic        io_softreg_req_bits_wr;
    logic        io_softreg_resp_ready;
    logic        io_softreg_resp_valid;
    logic [63:0] io_softreg_resp_bits_rdata;
    logic        err_unexpected_resp;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [63:0] wdata;
    } req_t;

    typedef struct packed {
        logic [1:0]  id;
        logic [63:0] data;
    } resp_t;

    req_t  exp_req[$];
    resp_t exp_resp[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    softreg_arbiter #(
        .NUM_REQ(2), .ADDR_W(32), .DATA_W(64), .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_wr(req_wr),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .io_softreg_req_ready(io_softreg_req_ready),
        .io_softreg_req_valid(io_softreg_req_valid),
        .io_softreg_req_bits_addr(io_softreg_req_bits_addr),
        .io_softreg_req_bits_wdata(io_softreg_req_bits_wdata),
        .io_softreg_req_bits_wr(io_softreg_req_bits_wr),
        .io_softreg_resp_ready(io_softreg_resp_ready),
        .io_softreg_resp_valid(io_softreg_resp_valid),
        .io_softreg_resp_bits_rdata(io_softreg_resp_bits_rdata),
        .err_unexpected_resp(err_unexpected_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic drive_req(input int i, input logic wr, input logic [31:0] addr, input logic [63:0] wd);
        req_valid[i]            = 1'b1;
        req_wr[i]               = wr;
        req_addr[i*32 +: 32]    = addr;
        req_wdata[i*64 +: 64]   = wd;
    endtask

    task automatic push_req(input logic [31:0] addr, input logic wr, input logic [63:0] wd);
        req_t e;
        e.addr  = addr;
        e.wr    = wr;
        e.wdata = wd;
        exp_req.push_back(e);
    endtask

    task automatic push_resp(input logic [1:0] id, input logic [63:0] data);
        resp_t e;
        e.id   = id;
        e.data = data;
        exp_resp.push_back(e);
        io_softreg_resp_valid      = 1'b1;
        io_softreg_resp_bits_rdata = data;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_valid"}, 64'(io_softreg_req_valid), 64'd0);
        chk({tag, "_req_addr"}, 64'(io_softreg_req_bits_addr), 64'd0);
        chk({tag, "_req_wdata"}, io_softreg_req_bits_wdata, 64'd0);
        chk({tag, "_req_wr"}, 64'(io_softreg_req_bits_wr), 64'd0);
        chk({tag, "_resp_ready"}, 64'(io_softreg_resp_ready), 64'd0);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 64'd0);
        chk({tag, "_err"}, 64'(err_unexpected_resp), 64'd0);
    endtask

    // Scoreboard monitor: every MIDAS request handshake and every response strobe is popped and compared.
    always @(negedge clk) begin
        if (rst_n) begin
            if (io_softreg_req_valid && io_softreg_req_ready) begin
                n_checks++;
                assert (exp_req.size() > 0) else begin
                    n_fail++;
                    $error("FAIL req_unexpected: observed addr %0h expected no request", io_softreg_req_bits_addr);
                end
                if (exp_req.size() > 0) begin
                    req_t e;
                    e = exp_req.pop_front();
                    chk("mon_req_addr", 64'(io_softreg_req_bits_addr), 64'(e.addr));
                    chk("mon_req_wr", 64'(io_softreg_req_bits_wr), 64'(e.wr));
                    chk("mon_req_wdata", io_softreg_req_bits_wdata, e.wdata);
                end
            end
            if (resp_valid != 2'b00) begin
                n_checks++;
                assert (exp_resp.size() > 0) else begin
                    n_fail++;
                    $error("FAIL resp_unexpected: observed resp_valid %0b expected 00", resp_valid);
                end
                if (exp_resp.size() > 0) begin
                    resp_t r;
                    r = exp_resp.pop_front();
                    chk("mon_resp_valid", 64'(resp_valid), 64'(r.id));
                    chk("mon_resp_rdata", resp_rdata, r.data);
                end
            end
        end
    end

    initial begin
        rst_n                      = 1'b0;
        req_valid                  = 2'b00;
        req_wr                     = 2'b00;
        req_addr                   = '0;
        req_wdata                  = '0;
        io_softreg_req_ready       = 1'b1;
        io_softreg_resp_valid      = 1'b0;
        io_softreg_resp_bits_rdata = '0;

        // Reset state
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single read from requester 1
        drive_req(1, 1'b0, 32'h10, 64'h0);
        push_req(32'h10, 1'b0, 64'h0);
        samp();
        chk("t1_grant", 64'(req_ready), 64'h2);
        chk("t1_no_valid_yet", 64'(io_softreg_req_valid), 64'd0);
        tick();
        req_valid = 2'b00;
        samp();
        chk("t1_valid_latency", 64'(io_softreg_req_valid), 64'd1);
        chk("t1_resp_ready", 64'(io_softreg_resp_ready), 64'd1);
        tick();
        tick();
        tick();
        push_resp(2'b10, 64'hDEAD_BEEF);
        samp();
        chk("t1_resp_valid", 64'(resp_valid), 64'h2);
        chk("t1_resp_rdata", resp_rdata, 64'hDEAD_BEEF);
        tick();
        io_softreg_resp_valid = 1'b0;
        samp();
        chk("t1_count_zero", 64'(io_softreg_resp_ready), 64'd0);
        tick();

        // Fairness with back-to-back writes
        drive_req(0, 1'b1, 32'h100, 64'h1111);
        drive_req(1, 1'b1, 32'h200, 64'h2222);
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) push_req(32'h100, 1'b1, 64'h1111);
            else            push_req(32'h200, 1'b1, 64'h2222);
            samp();
            chk("t2_grant", 64'(req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
            chk("t2_slot_valid", 64'(io_softreg_req_valid), (k == 0) ? 64'd0 : 64'd1);
            tick();
        end
        req_valid = 2'b00;
        samp();
        chk("t2_last_valid", 64'(io_softreg_req_valid), 64'd1);
        tick();
        samp();
        chk("t2_drained", 64'(io_softreg_req_valid), 64'd0);
        tick();

        // Backpressure
        drive_req(0, 1'b1, 32'h300, 64'h33);
        push_req(32'h300, 1'b1, 64'h33);
        samp();
        chk("t3_grant", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b00;
        drive_req(1, 1'b1, 32'h400, 64'h44);
        io_softreg_req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            samp();
            chk("t3_bp_ready", 64'(req_ready), 64'd0);
            chk("t3_bp_valid", 64'(io_softreg_req_valid), 64'd1);
            chk("t3_bp_addr", 64'(io_softreg_req_bits_addr), 64'h300);
            chk("t3_bp_wdata", io_softreg_req_bits_wdata, 64'h33);
            tick();
        end
        io_softreg_req_ready = 1'b1;
        push_req(32'h400, 1'b1, 64'h44);
        samp();
        chk("t3_reload", 64'(req_ready), 64'h2);
        tick();
        req_valid = 2'b00;
        samp();
        chk("t3_second_addr", 64'(io_softreg_req_bits_addr), 64'h400);
        tick();

        // Outstanding limit
        for (int k = 0; k < 4; k++) begin
            drive_req(0, 1'b0, 32'h500 + 32'(k), 64'h0);
            push_req(32'h500 + 32'(k), 1'b0, 64'h0);
            samp();
            chk("t4_read_grant", 64'(req_ready), 64'h1);
            tick();
        end
        drive_req(0, 1'b0, 32'h504, 64'h0);
        drive_req(1, 1'b1, 32'h600, 64'h66);
        push_req(32'h600, 1'b1, 64'h66);
        samp();
        chk("t4_write_passes", 64'(req_ready), 64'h2);
        tick();
        req_valid[1] = 1'b0;
        samp();
        chk("t4_fifth_held", 64'(req_ready), 64'd0);
        tick();
        push_resp(2'b01, 64'hA0);
        samp();
        chk("t4_held_at_resp", 64'(req_ready), 64'd0);
        chk("t4_resp0", 64'(resp_valid), 64'h1);
        tick();
        io_softreg_resp_valid = 1'b0;
        push_req(32'h504, 1'b0, 64'h0);
        samp();
        chk("t4_fifth_issues", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            push_resp(2'b01, 64'hA0 + 64'(k));
            samp();
            chk("t4_resp_route", 64'(resp_valid), 64'h1);
            tick();
        end
        io_softreg_resp_valid = 1'b0;
        samp();
        chk("t4_count_zero", 64'(io_softreg_resp_ready), 64'd0);
        tick();

        // Interleaved routing, with a response coinciding with a read grant
        drive_req(0, 1'b0, 32'h700, 64'h0);
        push_req(32'h700, 1'b0, 64'h0);
        samp();
        chk("t5_grant_a", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b00;
        drive_req(1, 1'b0, 32'h710, 64'h0);
        push_req(32'h710, 1'b0, 64'h0);
        samp();
        chk("t5_grant_b", 64'(req_ready), 64'h2);
        tick();
        drive_req(1, 1'b0, 32'h720, 64'h0);
        push_req(32'h720, 1'b0, 64'h0);
        push_resp(2'b01, 64'hAAAA);
        samp();
        chk("t5_grant_c", 64'(req_ready), 64'h2);
        chk("t5_resp_a", 64'(resp_valid), 64'h1);
        tick();
        req_valid = 2'b00;
        drive_req(0, 1'b0, 32'h730, 64'h0);
        push_req(32'h730, 1'b0, 64'h0);
        push_resp(2'b10, 64'hBBBB);
        samp();
        chk("t5_grant_d", 64'(req_ready), 64'h1);
        chk("t5_resp_b", 64'(resp_valid), 64'h2);
        tick();
        req_valid = 2'b00;
        push_resp(2'b10, 64'hCCCC);
        samp();
        chk("t5_resp_c", 64'(resp_valid), 64'h2);
        tick();
        push_resp(2'b01, 64'hDDDD);
        samp();
        chk("t5_resp_d", 64'(resp_valid), 64'h1);
        chk("t5_last_outstanding", 64'(io_softreg_resp_ready), 64'd1);
        tick();
        io_softreg_resp_valid = 1'b0;
        samp();
        chk("t5_count_zero", 64'(io_softreg_resp_ready), 64'd0);
        tick();

        // Unexpected response
        io_softreg_resp_valid      = 1'b1;
        io_softreg_resp_bits_rdata = 64'hBAD;
        samp();
        chk("t6_no_resp_valid", 64'(resp_valid), 64'd0);
        chk("t6_no_rdata", resp_rdata, 64'd0);
        tick();
        io_softreg_resp_valid = 1'b0;
        samp();
        chk("t6_err_set", 64'(err_unexpected_resp), 64'd1);
        tick();

        // Reset mid-transfer with a read parked in the slot
        io_softreg_req_ready = 1'b0;
        drive_req(0, 1'b0, 32'h800, 64'h0);
        samp();
        chk("t6_park_grant", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b00;
        samp();
        chk("t6_parked", 64'(io_softreg_req_valid), 64'd1);
        chk("t6_parked_tag", 64'(io_softreg_resp_ready), 64'd1);
        rst_n = 1'b0;
        #2;
        chk_all_zero("t6_in_reset");
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        io_softreg_req_ready = 1'b1;
        #1;
        chk_all_zero("t6_after_reset");
        tick();

        // Pointer restarts at 0; then a stale response is flagged
        drive_req(0, 1'b0, 32'h900, 64'h0);
        drive_req(1, 1'b0, 32'h910, 64'h0);
        push_req(32'h900, 1'b0, 64'h0);
        samp();
        chk("t6_ptr_zero", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b00;
        samp();
        tick();
        push_resp(2'b01, 64'h99);
        samp();
        chk("t6_final_resp", 64'(resp_valid), 64'h1);
        tick();
        io_softreg_resp_valid = 1'b0;
        samp();
        chk("t6_err_clear", 64'(err_unexpected_resp), 64'd0);
        tick();
        io_softreg_resp_valid      = 1'b1;
        io_softreg_resp_bits_rdata = 64'h77;
        samp();
        chk("t6_stale_dropped", 64'(resp_valid), 64'd0);
        tick();
        io_softreg_resp_valid = 1'b0;
        samp();
        chk("t6_stale_err", 64'(err_unexpected_resp), 64'd1);
        tick();

        chk("req_queue_left", 64'(exp_req.size()), 64'd0);
        chk("resp_queue_left", 64'(exp_resp.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/softreg_arbiter.md
Name: softreg_arbiter

Overview:
- Shares the single MIDAS soft-register channel (io_softreg_req_* / io_softreg_resp_*) between NUM_REQ on-chip requesters. Examples: the host soft-shell bridge and a debug/trace sequencer.
- Arbitrates round-robin and registers the winning request into a one-entry output slot.
- Records the requester ID of every read in an in-order tag FIFO, so each read response is routed back to its issuer.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 32, soft-register address width.
- DATA_W, 64, soft-register data width.
- MAX_OUTSTANDING, 4, maximum reads in flight; power of two, 2..16.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester request accepted.
- req_wr  in  NUM_REQ  per-requester type: 1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing.
- resp_valid  out  NUM_REQ  one-hot read-response strobe.
- resp_rdata  out  DATA_W  read data, shared by all requesters; qualified by resp_valid.
- io_softreg_req_ready  in  1  MIDAS accepts the request.
- io_softreg_req_valid  out  1  request to MIDAS.
- io_softreg_req_bits_addr  out  ADDR_W  request address.
- io_softreg_req_bits_wdata  out  DATA_W  request write data.
- io_softreg_req_bits_wr  out  1  request type.
- io_softreg_resp_ready  out  1  ready for a MIDAS response.
- io_softreg_resp_valid  in  1  MIDAS response valid.
- io_softreg_resp_bits_rdata  in  DATA_W  response data.
- err_unexpected_resp  out  1  sticky error: a response arrived with no read outstanding.

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - all outputs 0;
  - slot empty, tag FIFO empty, outstanding count 0;
  - round-robin pointer 0, so requester 0 has highest priority first.
- Eligibility:
  - requester i is eligible when req_valid[i]=1 and (req_wr[i]=1 or outstanding count + reads-in-slot < MAX_OUTSTANDING);
  - a read in the slot counts as outstanding from the cycle it is accepted.
- Arbitration:
  - the slot can load when it is empty, or when it is full and io_softreg_req_ready=1 in the same cycle (full throughput, one request per cycle);
  - the winner is the first eligible requester at or after the pointer, wrapping modulo NUM_REQ;
  - req_ready[winner]=1 only that cycle; req_ready is a combinational function of req_valid, req_wr and state;
  - after a grant, the pointer becomes winner+1 mod NUM_REQ; with no grant, the pointer holds.
- Slot:
  - registered; latency from grant to io_softreg_req_valid is 1 cycle;
  - addr/wdata/wr are stable while valid=1 and ready=0;
  - valid drops the cycle after a handshake unless the slot reloads.
- Tag FIFO:
  - depth MAX_OUTSTANDING, width clog2(NUM_REQ);
  - pushes the winner ID when a read is loaded into the slot.
- Outstanding count:
  - increments on a read grant;
  - decrements on a response handshake;
  - both in the same cycle leaves it unchanged;
  - never exceeds MAX_OUTSTANDING, and never issues a read past the limit (eligibility blocks it).
- Responses:
  - io_softreg_resp_ready = 1 when the tag FIFO is non-empty;
  - on io_softreg_resp_valid && resp_ready: pop the FIFO and, in the same cycle, drive resp_valid[head]=1 and resp_rdata=io_softreg_resp_bits_rdata (combinational pass-through);
  - requesters cannot backpressure responses;
  - MIDAS returns responses in order; writes produce no response.
- Unexpected response:
  - io_softreg_resp_valid with the FIFO empty is ignored: no pop, no resp_valid;
  - it sets err_unexpected_resp, which is cleared only by reset.
- Pointer wrap: requester NUM_REQ-1 followed by requester 0.
- Reset mid-operation clears slot, FIFO and count.
  - In-flight MIDAS responses after reset are flagged via err_unexpected_resp.
  - Requesters must retry.

Test Plan:
- Single read, NUM_REQ=2:
  - stimulus: req 1 reads addr 0x10; MIDAS returns 0xDEAD_BEEF 3 cycles after the handshake;
  - required: io_softreg_req_valid 1 cycle after the grant; resp_valid=2'b10 with that data; count returns to 0.
- Fairness:
  - stimulus: both requesters hold req_valid with back-to-back writes, io_softreg_req_ready=1;
  - required: grants alternate 0,1,0,1; one request issued per cycle.
- Backpressure:
  - stimulus: io_softreg_req_ready=0 for 5 cycles;
  - required: slot fields stable, req_ready=0 for all requesters; the handshake occurs on the cycle ready rises.
- Outstanding limit:
  - stimulus: 5 reads from req 0 with no responses, MAX_OUTSTANDING=4;
  - required: 4 issued and the 5th held; a write from req 1 still issues; the 5th issues the cycle after the first response.
- Interleaved routing:
  - stimulus: reads from requesters 0,1,1,0 with responses A,B,C,D, including a response arriving in the same cycle as a new read grant;
  - required: resp_valid sequence 01,10,10,01 with data A..D; count consistent throughout.
- Error and reset:
  - stimulus: response with nothing outstanding, then rst_n pulsed low mid-transfer;
  - required: err_unexpected_resp=1 and no resp_valid; after reset all outputs are 0 and the pointer is 0.
